// File: rtl/ext_domain_pwr_seq.sv
// ext_domain_pwr_seq: per-domain external power switch / isolation / reset sequencer.
// Define EXT_PWR_SEQ_TIMEOUT_EN to add the sticky switch-ack timeout.
module ext_domain_pwr_seq #(
    parameter int N_DOMAINS     = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_DOMAINS-1:0] pwr_on_req_i,
    input  logic [N_DOMAINS-1:0] pwr_off_req_i,
    input  logic [N_DOMAINS-1:0] switch_ack_i,
    input  logic [N_DOMAINS-1:0] clr_timeout_i,
    output logic [N_DOMAINS-1:0] switch_en_o,
    output logic [N_DOMAINS-1:0] iso_o,
    output logic [N_DOMAINS-1:0] rst_no,
    output logic [N_DOMAINS-1:0] on_o,
    output logic [N_DOMAINS-1:0] busy_o,
    output logic [N_DOMAINS-1:0] timeout_o
);
    localparam int MAXC = (SETTLE_CYCLES > ACK_TIMEOUT) ? SETTLE_CYCLES : ACK_TIMEOUT;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXC);
`ifdef EXT_PWR_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {OFF, PWR_UP, SETTLE, ISO_OFF, ON, RST_ON, ISO_ON, PWR_DN} state_t;

    for (genvar g = 0; g < N_DOMAINS; g++) begin : g_dom
        state_t        r_state;
        state_t        w_next;
        logic [CW-1:0] r_cnt;
        logic          w_cnt_en;
`ifdef EXT_PWR_SEQ_TIMEOUT_EN
        logic          w_timeout;
        logic          r_to;
        assign w_cnt_en = (r_state == SETTLE) || (r_state == PWR_UP) || (r_state == PWR_DN);
`else
        assign w_cnt_en = (r_state == SETTLE);
`endif

        // Counter restarts on every state change and saturates instead of wrapping.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_state <= OFF;
                r_cnt   <= '0;
            end else begin
                r_state <= w_next;
                r_cnt   <= (w_next != r_state) ? '0 :
                           (w_cnt_en && r_cnt != CNT_MAX) ? r_cnt + 1'b1 : r_cnt;
            end
        end

        always_comb begin
            w_next = r_state;
`ifdef EXT_PWR_SEQ_TIMEOUT_EN
            w_timeout = 1'b0;
`endif
            case (r_state)
                OFF:     if (pwr_on_req_i[g]) w_next = PWR_UP;
                PWR_UP: begin
                    if (switch_ack_i[g]) w_next = SETTLE;
`ifdef EXT_PWR_SEQ_TIMEOUT_EN
                    else if (r_cnt == TO_LAST) begin
                        w_next    = OFF;
                        w_timeout = 1'b1;
                    end
`endif
                end
                SETTLE:  if (r_cnt == SETTLE_LAST) w_next = ISO_OFF;
                ISO_OFF: w_next = ON;
                ON:      if (pwr_off_req_i[g]) w_next = RST_ON;
                RST_ON:  w_next = ISO_ON;
                ISO_ON:  w_next = PWR_DN;
                PWR_DN: begin
                    if (!switch_ack_i[g]) w_next = OFF;
`ifdef EXT_PWR_SEQ_TIMEOUT_EN
                    else if (r_cnt == TO_LAST) begin
                        w_next    = OFF;
                        w_timeout = 1'b1;
                    end
`endif
                end
                default: w_next = OFF;
            endcase
        end

`ifdef EXT_PWR_SEQ_TIMEOUT_EN
        // A fresh timeout outranks a simultaneous clear.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) r_to <= 1'b0;
            else       r_to <= w_timeout | (r_to & ~clr_timeout_i[g]);
        end
        assign timeout_o[g] = r_to;
`endif

        assign switch_en_o[g] = (r_state != OFF) && (r_state != PWR_DN);
        assign iso_o[g]       = r_state inside {OFF, PWR_UP, SETTLE, ISO_ON, PWR_DN};
        assign rst_no[g]      = (r_state == ON);
        assign on_o[g]        = (r_state == ON);
        assign busy_o[g]      = (r_state != OFF) && (r_state != ON);
    end

`ifndef EXT_PWR_SEQ_TIMEOUT_EN
    logic w_unused_clr;
    assign w_unused_clr = ^clr_timeout_i;
    assign timeout_o    = '0;
`endif
endmodule

// File: tb/tb_ext_domain_pwr_seq.sv
// tb_ext_domain_pwr_seq: random + directed check of the power sequencer against a phase model.
module tb_ext_domain_pwr_seq;
    localparam int N  = 4;
    localparam int SC = 4;
    localparam int AT = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] on_req = '0, off_req = '0, ack = '0, clr = '0;
    logic [N-1:0] sw, iso, rstn, on, busy, to;
    int           total = 0, bad = 0;

    // Phases 0..7: off, up, settle, iso_off, on, rst_on, iso_on, dn.
    int           ph[N], left[N], waitc[N], lag[N], dly[N];
    bit           mto[N], hold[N];
    logic [7:0]   sw_t  = 8'b0111_1110;
    logic [7:0]   iso_t = 8'b1100_0111;
    logic [7:0]   rn_t  = 8'b0001_0000;

    ext_domain_pwr_seq #(.N_DOMAINS(N), .SETTLE_CYCLES(SC), .ACK_TIMEOUT(AT)) dut (
        .clk_i(clk), .rst_i(rst), .pwr_on_req_i(on_req), .pwr_off_req_i(off_req),
        .switch_ack_i(ack), .clr_timeout_i(clr), .switch_en_o(sw), .iso_o(iso),
        .rst_no(rstn), .on_o(on), .busy_o(busy), .timeout_o(to)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [N-1:0] e_sw, e_iso, e_rn, e_on, e_busy, e_to;
        for (int i = 0; i < N; i++) begin
            e_sw[i]   = sw_t[ph[i]];
            e_iso[i]  = iso_t[ph[i]];
            e_rn[i]   = rn_t[ph[i]];
            e_on[i]   = (ph[i] == 4);
            e_busy[i] = (ph[i] != 0) && (ph[i] != 4);
            e_to[i]   = mto[i];
        end
        chk("switch_en", 32'(sw), 32'(e_sw));
        chk("iso", 32'(iso), 32'(e_iso));
        chk("rst_n", 32'(rstn), 32'(e_rn));
        chk("on", 32'(on), 32'(e_on));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("timeout", 32'(to), 32'(e_to));
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            ph[i] = 0; left[i] = 0; waitc[i] = 0; mto[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            bit tnew = 0;
            case (ph[i])
                0: if (on_req[i]) begin ph[i] = 1; waitc[i] = 0; end
                1: if (ack[i]) begin ph[i] = 2; left[i] = SC; end
                   else begin
                       waitc[i]++;
`ifdef EXT_PWR_SEQ_TIMEOUT_EN
                       if (waitc[i] == AT) begin ph[i] = 0; tnew = 1; end
`endif
                   end
                2: begin left[i]--; if (left[i] == 0) ph[i] = 3; end
                3: ph[i] = 4;
                4: if (off_req[i]) ph[i] = 5;
                5: ph[i] = 6;
                6: begin ph[i] = 7; waitc[i] = 0; end
                default: if (!ack[i]) ph[i] = 0;
                   else begin
                       waitc[i]++;
`ifdef EXT_PWR_SEQ_TIMEOUT_EN
                       if (waitc[i] == AT) begin ph[i] = 0; tnew = 1; end
`endif
                   end
            endcase
`ifdef EXT_PWR_SEQ_TIMEOUT_EN
            mto[i] = tnew | (mto[i] & ~clr[i]);
`else
            mto[i] = tnew;
`endif
        end
    endtask

    // The emulated power switch follows the expected enable after dly[i] cycles.
    task automatic drive_ack();
        for (int i = 0; i < N; i++) begin
            logic want;
            want = sw_t[ph[i]] & ~hold[i];
            if (ack[i] != want) begin
                if (lag[i] >= dly[i]) begin ack[i] = want; lag[i] = 0; end
                else lag[i]++;
            end else lag[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        drive_ack();
        on_req = '0; off_req = '0; clr = '0;
    endtask

    task automatic areset();
        #1 rst = 1'b1;
        #1 model_reset();
        check_all();
        chk("rst_async_on", 32'(on), 32'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        int ea, ei, er;
        for (int i = 0; i < N; i++) begin lag[i] = 0; dly[i] = 0; hold[i] = 0; end
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        chk("reset_iso", 32'(iso), 32'hF);
        rst = 1'b0;
        repeat (3) tick();

        // Domain 0: ack two cycles late; isolation and reset release timing.
        dly[0] = 2;
        on_req[0] = 1'b1;
        tick();
        ea = -1; ei = -1; er = -1;
        for (int k = 1; k <= 30; k++) begin
            if (ack[0] && ea < 0) ea = k;
            tick();
            if (!iso[0] && ei < 0) ei = k;
            if (rstn[0] && er < 0) er = k;
        end
        chk("iso_fall_delay", 32'(ei - ea), 32'd4);
        chk("rstn_rise_delay", 32'(er - ea), 32'd5);

        // Domain 1: power down sequence order.
        dly[1] = 1;
        on_req[1] = 1'b1;
        repeat (13) tick();
        chk("d1_on", 32'(on[1]), 32'd1);
        off_req[1] = 1'b1;
        tick();
        chk("d1_rstn_low", 32'(rstn[1]), 32'd0);
        tick();
        chk("d1_iso_high", 32'(iso[1]), 32'd1);
        tick();
        chk("d1_sw_low", 32'(sw[1]), 32'd0);
        repeat (5) tick();
        chk("d1_off", 32'(busy[1]), 32'd0);

        // Domain 2: simultaneous requests in OFF, SETTLE and ON.
        on_req[2] = 1'b1; off_req[2] = 1'b1;
        tick();
        chk("d2_up_wins", 32'(busy[2]), 32'd1);
        tick();
        on_req[2] = 1'b1; off_req[2] = 1'b1;
        tick();
        repeat (8) tick();
        chk("d2_on", 32'(on[2]), 32'd1);
        on_req[2] = 1'b1; off_req[2] = 1'b1;
        tick();
        chk("d2_off_wins", 32'(rstn[2]), 32'd0);
        repeat (10) tick();
        chk("d2_stays_off", 32'(busy[2] | on[2]), 32'd0);

        // Async reset with domain 3 ON and domain 2 in SETTLE.
        on_req[3] = 1'b1;
        repeat (10) tick();
        on_req[2] = 1'b1;
        repeat (2) tick();
        chk("d3_on_pre_rst", 32'(on[3]), 32'd1);
        areset();
        repeat (10) tick();
        chk("no_on_after_rst", 32'(on), 32'd0);

`ifdef EXT_PWR_SEQ_TIMEOUT_EN
        hold[1] = 1;
        on_req[1] = 1'b1;
        tick();
        repeat (10) tick();
        chk("d1_timeout_set", 32'(to[1]), 32'd1);
        clr[1] = 1'b1;
        tick();
        chk("d1_timeout_clr", 32'(to[1]), 32'd0);
        hold[1] = 0;
`endif

        // Concurrent random traffic with per-domain ack delays.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 63) == 0) dly[i] = $urandom_range(0, 5);
`ifdef EXT_PWR_SEQ_TIMEOUT_EN
                if ($urandom_range(0, 99) == 0) hold[i] = !hold[i];
`endif
            end
            on_req  = N'($urandom & $urandom & $urandom);
            off_req = N'($urandom & $urandom & $urandom);
            clr     = N'($urandom & $urandom);
            tick();
            if ($urandom_range(0, 399) == 0) areset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ext_domain_pwr_seq.md
EXT_DOMAIN_PWR_SEQ -- requirements
Module: ext_domain_pwr_seq

Interface
REQ-001 Parameter N_DOMAINS, default 4: number of independently sequenced external power domains (1..16).
REQ-002 Parameter SETTLE_CYCLES, default 8: cycles waited after switch ack before isolation release (1..255).
REQ-003 Parameter ACK_TIMEOUT, default 255: max cycles waited for a switch ack (1..65535).
REQ-004 clk_i  input  1  single clock; all state on its rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 pwr_on_req_i  input  N_DOMAINS  per-domain one-cycle power-up request.
REQ-007 pwr_off_req_i  input  N_DOMAINS  per-domain one-cycle power-down request.
REQ-008 switch_ack_i  input  N_DOMAINS  power-switch acknowledge, already synchronised to clk_i, 1 = supply present.
REQ-009 clr_timeout_i  input  N_DOMAINS  per-domain one-cycle clear of timeout flag.
REQ-010 switch_en_o  output  N_DOMAINS  1 = power switch closed (supply applied).
REQ-011 iso_o  output  N_DOMAINS  1 = domain outputs isolated.
REQ-012 rst_no  output  N_DOMAINS  active-low domain logic reset.
REQ-013 on_o  output  N_DOMAINS  1 = domain in ON state.
REQ-014 busy_o  output  N_DOMAINS  1 = domain in any transitional state.
REQ-015 timeout_o  output  N_DOMAINS  sticky ack-timeout flag.

Function
REQ-016 Each domain SHALL have an independent registered FSM: OFF, PWR_UP, SETTLE, ISO_OFF, ON, RST_ON, ISO_ON, PWR_DN.
REQ-017 Outputs per state SHALL be (switch_en, iso, rst_n): OFF 0,1,0; PWR_UP 1,1,0; SETTLE 1,1,0; ISO_OFF 1,0,0; ON 1,0,1; RST_ON 1,0,0; ISO_ON 1,1,0; PWR_DN 0,1,0; all outputs SHALL be registered/decoded from state only.
REQ-018 OFF -> PWR_UP on pwr_on_req_i; ON -> RST_ON on pwr_off_req_i; requests in any other state SHALL be ignored (not queued).
REQ-019 Simultaneous on and off request: in OFF the on request SHALL win; in ON the off request SHALL win.
REQ-020 PWR_UP -> SETTLE on the first edge where switch_ack_i=1; SETTLE SHALL last exactly SETTLE_CYCLES cycles, then ISO_OFF (one cycle), then ON.
REQ-021 RST_ON and ISO_ON SHALL each last exactly one cycle; ISO_ON -> PWR_DN; PWR_DN -> OFF on the first edge where switch_ack_i=0.
REQ-022 on_o SHALL be 1 only in ON; busy_o SHALL be 1 in every state except OFF and ON.
REQ-023 Per-domain cycle counter width SHALL be $clog2(max(SETTLE_CYCLES,ACK_TIMEOUT)+1); counter SHALL clear on every state change and never wrap.
REQ-024 timeout_o[i] SHALL stay set until clr_timeout_i[i] or reset; clear and a new timeout in the same cycle SHALL leave the flag set.

Reset
REQ-025 While rst_i=1 every domain SHALL be forced to OFF (switch_en_o=0, iso_o=1, rst_no=0, on_o=0, busy_o=0, timeout_o=0, counters 0), including mid-sequence.
REQ-026 After rst_i deasserts, no domain SHALL leave OFF without a new pwr_on_req_i.

Configuration
REQ-027 With EXT_PWR_SEQ_TIMEOUT_EN defined: in PWR_UP or PWR_DN, ACK_TIMEOUT cycles without the expected ack SHALL set timeout_o[i] and force the domain to OFF.
REQ-028 Without EXT_PWR_SEQ_TIMEOUT_EN: PWR_UP/PWR_DN SHALL wait indefinitely, timeout_o SHALL be tied 0, clr_timeout_i ignored, no timeout counter logic synthesised.

Verification
REQ-029 SETTLE_CYCLES=4, on req domain 0, ack high 2 cycles after switch_en_o rises -> iso_o[0] falls 4 cycles and rst_no[0] rises 5 cycles after first ack-high cycle; busy_o[0]=1 throughout.
REQ-030 Domain 1 ON, off req -> rst_no[1]=0 next cycle, iso_o[1]=1 one cycle later, switch_en_o[1]=0 one cycle later, OFF 1 cycle after ack drops.
REQ-031 Macro defined, ACK_TIMEOUT=10, ack never asserted -> timeout_o=1 and domain OFF after 10 PWR_UP cycles; clr_timeout_i clears it next cycle.
REQ-032 Simultaneous on+off in OFF and in ON, plus requests during SETTLE -> REQ-018/REQ-019 behaviour, no queued transitions.
REQ-033 rst_i pulsed asynchronously while domain 2 in SETTLE and domain 3 ON -> all outputs at reset values immediately, no glitch to ON afterwards.
REQ-034 Four domains sequenced concurrently with different ack delays -> each follows its own timing, no cross-domain interference.
